// File: rtl/imem_loader.sv
// Serial program loader: packs incoming bytes little-endian into 32-bit words,
// writes them to instruction memory and holds the core in reset until a full load.
module imem_loader #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [P_ADDR_WIDTH-2:0] i_word_count,
  input  logic [7:0]              i_byte,
  input  logic                    i_byte_valid,
  output logic                    o_byte_ready,
  output logic                    o_we,
  output logic [P_ADDR_WIDTH-1:0] o_waddr,
  output logic [P_DATA_WIDTH-1:0] o_wdata,
  output logic                    o_core_rst_n,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  // state | meaning
  // IDLE  | waiting for i_start; core released only if last load completed
  // RECV  | accepting serial bytes into the word assembler
  // WRITE | one-cycle write strobe of the assembled word
  // DONE  | one cycle, flags completion then returns to IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int IW = P_ADDR_WIDTH - 2;
  localparam int MAX_WORDS = 2 ** IW;
  localparam logic [P_ADDR_WIDTH-2:0] MAX_COUNT = MAX_WORDS[P_ADDR_WIDTH-2:0];

  state_t                  state;
  logic [1:0]              rst_sync;
  logic [IW-1:0]           word_idx;
  logic [IW-1:0]           word_nxt;
  logic [IW-1:0]           cnt_lat;
  logic [1:0]              byte_idx;
  logic [P_DATA_WIDTH-9:0] asm_word;
  logic                    count_ok;

  // A count of exactly MAX_WORDS truncates to 0, which word_nxt reaches after the last word.
  assign word_nxt = word_idx + 1'b1;
  assign count_ok = (i_word_count != '0) && (i_word_count <= MAX_COUNT);

  // Reset release is resynchronised; the FSM stays frozen until rst_sync[1] is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      word_idx     <= '0;
      cnt_lat      <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
      o_byte_ready <= 1'b0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_core_rst_n <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else if (rst_sync[1]) begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_done       <= 1'b0;
            o_core_rst_n <= 1'b0;
            if (count_ok) begin
              cnt_lat      <= i_word_count[IW-1:0];
              word_idx     <= '0;
              byte_idx     <= '0;
              o_err        <= 1'b0;
              o_busy       <= 1'b1;
              o_byte_ready <= 1'b1;
              state        <= S_RECV;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (i_byte_valid && o_byte_ready) begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              o_wdata      <= {i_byte, asm_word};
              o_waddr      <= {word_idx, 2'b00};
              o_we         <= 1'b1;
              o_byte_ready <= 1'b0;
              state        <= S_WRITE;
            end else begin
              asm_word <= {i_byte, asm_word[P_DATA_WIDTH-9:8]};
            end
          end
        end
        S_WRITE: begin
          o_we <= 1'b0;
          if (word_nxt == cnt_lat) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            word_idx     <= word_nxt;
            o_byte_ready <= 1'b1;
            state        <= S_RECV;
          end
        end
        S_DONE: begin
          o_core_rst_n <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams in, write strobes checked against
// words built by the bench from the same byte table.
module tb_imem_loader;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [8:0] i_word_count;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_byte_ready;
  logic       o_we;
  logic [9:0] o_waddr;
  logic [31:0] o_wdata;
  logic       o_core_rst_n;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int we_cnt   = 0;
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  stim [0:1023];

  imem_loader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_core_rst_n (o_core_rst_n),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_we) begin
      we_cnt++;
      wr_addr_q.push_back(o_waddr);
      wr_data_q.push_back(o_wdata);
      check("rdy_in_write", {31'd0, o_byte_ready}, 32'd0);
    end
  end

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_word_count = 9'd0;
    i_byte = 8'd0;
    i_byte_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ctl", {26'd0, o_byte_ready, o_we, o_busy, o_done, o_err, o_core_rst_n}, 32'd0);
    check("rst_waddr", {22'd0, o_waddr}, 32'd0);
    check("rst_wdata", o_wdata, 32'd0);
    // start held across release must not be taken on the first edge
    i_start = 1'b1;
    i_word_count = 9'd1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("sync_first_edge", {31'd0, o_busy}, 32'd0);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic load(input int cnt, input int nbytes, input bit toggle,
                      input int inj_at, input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_word_count = cnt[8:0];
    @(negedge i_clk);
    i_start = 1'b0;
    while (idx < nbytes && cyc < 5000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      i_byte = stim[idx];
      i_byte_valid = toggle ? ph : 1'b1;
      ph = !ph;
      i_start = (idx == inj_at);
      i_word_count = (idx == inj_at) ? 9'd5 : cnt[8:0];
      if (i_byte_valid && o_byte_ready) idx++;
      cyc++;
      if (!(abort_at >= 0 && idx == abort_at)) @(negedge i_clk);
    end
    i_byte_valid = 1'b0;
    i_start = 1'b0;
    check("feed_budget", {31'd0, cyc < 5000}, 32'd1);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!o_done && cyc < 50) begin
      @(negedge i_clk);
      cyc++;
    end
    check("done", {31'd0, o_done}, 32'd1);
    @(negedge i_clk);
    check("core_rst_rel", {30'd0, o_core_rst_n, o_busy}, 32'd2);
  endtask

  task automatic verify(input int base, input int nwords);
    logic [31:0] exp;
    check("we_count", we_cnt - base, nwords);
    for (int w = 0; w < nwords && base + w < we_cnt; w++) begin
      exp = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
      check($sformatf("addr_w%0d", w), {22'd0, wr_addr_q[base+w]}, 4*w);
      check($sformatf("data_w%0d", w), wr_data_q[base+w], exp);
    end
  endtask

  task automatic bad_count(input logic [8:0] cnt);
    int base;
    base = we_cnt;
    @(negedge i_clk);
    i_start = 1'b1;
    i_word_count = cnt;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    check($sformatf("err_%0d", cnt), {29'd0, o_err, o_busy, o_core_rst_n}, 32'd4);
    check($sformatf("err_done_%0d", cnt), {31'd0, o_done}, 32'd0);
    check($sformatf("err_we_%0d", cnt), we_cnt - base, 0);
  endtask

  initial begin
    int base;
    do_reset();

    // single word 0x00000013
    foreach (stim[i]) stim[i] = 8'h00;
    stim[0] = 8'h13;
    base = we_cnt;
    load(1, 4, 1'b0, -1, -1);
    wait_done();
    verify(base, 1);
    if (we_cnt > base) check("w13_const", wr_data_q[base], 32'h0000_0013);

    // three words, valid toggling
    for (int i = 0; i < 12; i++) stim[i] = 8'(i + 1);
    base = we_cnt;
    load(3, 12, 1'b1, -1, -1);
    wait_done();
    verify(base, 3);
    if (we_cnt > base + 2) check("w3_const", wr_data_q[base+2], 32'h0C0B_0A09);

    // illegal counts
    bad_count(9'd0);
    bad_count(9'd257);

    // full memory
    for (int i = 0; i < 1024; i++) stim[i] = 8'(i);
    base = we_cnt;
    load(256, 1024, 1'b0, -1, -1);
    wait_done();
    verify(base, 256);
    check("full_last_addr", {22'd0, wr_addr_q[wr_addr_q.size()-1]}, 32'h3FC);
    check("full_last_data", wr_data_q[wr_data_q.size()-1], 32'hFFFE_FDFC);
    check("err_cleared", {31'd0, o_err}, 32'd0);

    // start during RECV is ignored
    for (int i = 0; i < 8; i++) stim[i] = 8'(8'hA0 + i);
    base = we_cnt;
    load(2, 8, 1'b0, 3, -1);
    wait_done();
    verify(base, 2);

    // async abort after byte 2 of word 5
    for (int i = 0; i < 32; i++) stim[i] = 8'(8'h40 + i);
    base = we_cnt;
    load(8, 32, 1'b0, -1, 23);
    check("abort_pre_writes", we_cnt - base, 5);
    #2 i_rst_n = 1'b0;
    #1;
    check("abort_ctl", {26'd0, o_byte_ready, o_we, o_busy, o_done, o_err, o_core_rst_n}, 32'd0);
    check("abort_wdata", {o_wdata[31:10], o_wdata[9:0] | o_waddr}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    base = we_cnt;
    i_byte_valid = 1'b1;
    repeat (20) @(negedge i_clk);
    i_byte_valid = 1'b0;
    check("abort_no_we", we_cnt - base, 0);
    check("abort_idle", {30'd0, o_done, o_core_rst_n}, 32'd0);

    // recovery load
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
    base = we_cnt;
    load(1, 4, 1'b0, -1, -1);
    wait_done();
    verify(base, 1);
    if (we_cnt > base) check("recover_const", wr_data_q[base], 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter P_DATA_WIDTH, default 32, instruction word width in bits; only 32 is supported.
REQ-002 Parameter P_ADDR_WIDTH, default 10, byte address width of the instruction memory (1 KB, 256 words).
REQ-003 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port i_start  input  1  single-cycle request to begin a program load.
REQ-006 Port i_word_count  input  P_ADDR_WIDTH-1  number of words to load; sampled when i_start is accepted; legal range 1..256.
REQ-007 Port i_byte  input  8  serial program byte.
REQ-008 Port i_byte_valid  input  1  i_byte holds a valid byte.
REQ-009 Port o_byte_ready  output  1  loader accepts i_byte this cycle.
REQ-010 Port o_we  output  1  instruction memory write strobe.
REQ-011 Port o_waddr  output  P_ADDR_WIDTH  byte address of the write; bits [1:0] always 0.
REQ-012 Port o_wdata  output  P_DATA_WIDTH  assembled instruction word.
REQ-013 Port o_core_rst_n  output  1  active-low reset to the processor core.
REQ-014 Port o_busy  output  1  a load is in progress.
REQ-015 Port o_done  output  1  last load completed successfully.
REQ-016 Port o_err  output  1  last i_start had an illegal i_word_count.

Function
REQ-017 States: IDLE, RECV, WRITE, DONE.
REQ-018 Byte handshake: a byte is transferred in a cycle where i_byte_valid and o_byte_ready are both 1.
REQ-019 o_byte_ready = 1 only in RECV; 0 in IDLE, WRITE and DONE.
REQ-020 IDLE: on i_start with 1 <= i_word_count <= 256, latch the count, clear the word index and byte index, clear o_done and o_err, and go to RECV.
REQ-021 IDLE: on i_start with i_word_count = 0 or > 256, set o_err = 1, clear o_done, and stay in IDLE.
REQ-022 RECV: bytes are packed little-endian; byte k (k = 0..3) goes to o_wdata[8k+7:8k]; the byte index increments mod 4.
REQ-023 RECV: the transfer of byte 3 moves the FSM to WRITE on the next edge.
REQ-024 WRITE: o_we = 1 for exactly one cycle, with o_waddr = word_index*4 and o_wdata = the assembled word.
REQ-025 WRITE exit, more words remaining: increment the word index and return to RECV.
REQ-026 WRITE exit, last word written: go to DONE.
REQ-027 Write latency: o_we is high in the cycle immediately after the cycle in which byte 3 is transferred.
REQ-028 The word index is 8 bits; word 255 is written to address 0x3FC; no write ever occurs beyond the latched count.
REQ-029 DONE lasts one cycle, sets o_done = 1 and returns to IDLE; o_done then holds until the next accepted i_start or reset.
REQ-030 o_busy = 1 in RECV and WRITE, 0 otherwise.
REQ-031 o_core_rst_n = 0 whenever o_busy = 1, and whenever o_done = 0.
REQ-032 o_core_rst_n = 1 only in IDLE with o_done = 1.
REQ-033 i_start is ignored in RECV, WRITE and DONE.
REQ-034 o_we = 0 in every state except WRITE.
REQ-035 o_wdata holds its last assembled value when o_we = 0.
REQ-036 i_byte_valid is ignored whenever o_byte_ready = 0; no byte is consumed outside RECV.

Reset
REQ-037 While i_rst_n = 0, regardless of the clock: FSM = IDLE, and the word index and byte index are 0.
REQ-038 While i_rst_n = 0, regardless of the clock, all outputs are 0: o_byte_ready, o_we, o_waddr, o_wdata, o_core_rst_n, o_busy, o_done and o_err.
REQ-039 Reset asserted mid-load aborts the load immediately: no further o_we, and o_done = 0, so the core stays in reset until a new complete load.
REQ-040 Deassertion is synchronised so that no state change occurs on the first clock edge after i_rst_n rises.

Verification
REQ-041 Reset, then i_start with count 1, then bytes 13,00,00,00 with valid held high -> one o_we, addr 0x000, data 0x00000013; o_done = 1; o_core_rst_n = 1.
REQ-042 Count 3, 12 bytes, valid toggled every other cycle -> o_we at addresses 0x000, 0x004, 0x008 with correct little-endian words; o_byte_ready = 0 during each WRITE cycle.
REQ-043 Count 0, then a separate test with count 257 -> o_err = 1, o_busy stays 0, no o_we, o_core_rst_n stays 0.
REQ-044 Count 256, incrementing pattern -> last write at 0x3FC; exactly 256 o_we pulses; DONE reached.
REQ-045 i_rst_n driven low between clock edges after byte 2 of word 5 -> all outputs 0 immediately; after release, no o_we until a new i_start.
REQ-046 i_start pulsed during RECV with a different count -> ignored; the original count completes.
